// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if
//   Bundles the three buses around the board RAM arbiter:
//     vga_*  : renderer read port (Avalon-MM style, read only)
//     cpu_*  : game-logic / Nios-bridge port (read and write)
//     mem_*  : single-port synchronous board RAM
//   Modports:
//     slave  : the arbiter's view (takes requests, drives the RAM)
//     master : the environment's view (masters plus the RAM itself)
//
//   Handshake: a request (vga_read, cpu_read or cpu_write) is accepted at a
//   rising edge when it is asserted and the matching waitrequest is low.
//   Masters hold address, data and control stable until accepted. Read data
//   comes back later, qualified by a one-cycle rvalid pulse.
interface board_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              vga_read;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_waitrequest;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;

    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_waitrequest;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vga_read, vga_addr,
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output vga_waitrequest, vga_rdata, vga_rvalid,
        output cpu_waitrequest, cpu_rdata, cpu_rvalid,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vga_read, vga_addr,
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  vga_waitrequest, vga_rdata, vga_rvalid,
        input  cpu_waitrequest, cpu_rdata, cpu_rvalid,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter
//   Shares one single-port synchronous board RAM between the VGA renderer
//   (read only, high priority) and the game-logic master (read/write).
//   Fixed priority with a starvation guard: after STARVE_MAX consecutive
//   denied CPU cycles the CPU is force-granted for one cycle.
//   Ports:
//     clk_clk        : system clock
//     reset_reset_n  : asynchronous active-low reset
//     bus            : vga_*, cpu_* and mem_* signals (slave modport)
//     dbg_tag        : read pipeline tag (NONE / VGA_RD / CPU_RD)
//     dbg_starve_cnt : current starvation counter
//   Read latency: a read accepted at edge n has its rvalid pulse in the
//   cycle after edge n+1 (RAM samples the address at n, data is captured
//   into the owner's rdata register at n+1).
module board_ram_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4   // legal range 1..15
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    board_ram_arbiter_if.slave  bus,
    output logic [1:0]          dbg_tag,
    output logic [3:0]          dbg_starve_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_VGA_RD = 2'd1,
        TAG_CPU_RD = 2'd2
    } tag_t;

    tag_t              tag_q, tag_d;
    logic [3:0]        starve_q, starve_d;
    logic              cpu_req;
    logic              force_cpu;
    logic              grant_vga, grant_cpu;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] vga_rdata_q, cpu_rdata_q;
    logic              vga_rvalid_q, cpu_rvalid_q;

    assign cpu_req   = bus.cpu_read | bus.cpu_write;
    assign force_cpu = cpu_req && (starve_q == STARVE_LIM);

    // Grants are held off during reset so the RAM sees no write and the
    // waitrequests stay high until reset_reset_n rises.
    always_comb begin
        grant_vga = 1'b0;
        grant_cpu = 1'b0;
        if (reset_reset_n) begin
            if (force_cpu)         grant_cpu = 1'b1;
            else if (bus.vga_read) grant_vga = 1'b1;
            else if (cpu_req)      grant_cpu = 1'b1;
        end
    end

    always_comb begin
        mem_addr_d = '0;
        if (grant_cpu)      mem_addr_d = bus.cpu_addr;
        else if (grant_vga) mem_addr_d = bus.vga_addr;
    end

    assign bus.vga_waitrequest = ~reset_reset_n | (bus.vga_read & ~grant_vga);
    assign bus.cpu_waitrequest = ~reset_reset_n | (cpu_req & ~grant_cpu);
    assign bus.mem_addr        = mem_addr_d;
    assign bus.mem_we          = grant_cpu & bus.cpu_write;
    assign bus.mem_wdata       = bus.cpu_wdata;

    // Next-state: tag records who owns the read sampled at this edge.
    // A CPU request with both read and write high is a write, so no tag.
    always_comb begin
        tag_d    = TAG_NONE;
        starve_d = starve_q;
        if (grant_vga)
            tag_d = TAG_VGA_RD;
        else if (grant_cpu && !bus.cpu_write)
            tag_d = TAG_CPU_RD;

        if (!cpu_req || grant_cpu)
            starve_d = 4'd0;
        else if (starve_q != STARVE_LIM)
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tag_q    <= TAG_NONE;
            starve_q <= 4'd0;
        end else begin
            tag_q    <= tag_d;
            starve_q <= starve_d;
        end
    end

    // Return path: one edge after acceptance the RAM output is valid and is
    // steered to the owner. rdata holds after the rvalid pulse.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            vga_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            vga_rvalid_q <= (tag_q == TAG_VGA_RD);
            cpu_rvalid_q <= (tag_q == TAG_CPU_RD);
            if (tag_q == TAG_VGA_RD) vga_rdata_q <= bus.mem_rdata;
            if (tag_q == TAG_CPU_RD) cpu_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.vga_rvalid = vga_rvalid_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.vga_rdata  = vga_rdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;

    assign dbg_tag        = tag_q;
    assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter
//   Drives the arbiter with a vector table (one row per cycle, combinational
//   outputs compared each row), a behavioural RAM, and a scoreboard that
//   queues expected read data and return cycle at each accepted read and
//   checks them against the rvalid pulses. A hand-written sequence covers
//   reset in the middle of a read.
module tb_board_ram_arbiter;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [1:0] dbg_tag;
    logic [3:0] dbg_starve_cnt;

    board_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    board_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .bus            (bus),
        .dbg_tag        (dbg_tag),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- clock ----------------
    always #10 clk_clk = ~clk_clk;

    // ---------------- counters / check ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM model ----------------
    logic [7:0] ram [0:255];
    logic       ram_loaded = 1'b0;

    always @(posedge clk_clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
            ram[5]     <= 8'h3C;
            ram_loaded <= 1'b1;
            bus.mem_rdata <= 8'h00;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] vga_exp_q[$];
    int         vga_cyc_q[$];
    logic [7:0] cpu_exp_q[$];
    int         cpu_cyc_q[$];
    int         edge_cnt = 0;

    // Acceptance monitor: expected data comes from the bench RAM at the
    // requested address; rvalid is due one edge after acceptance.
    always @(posedge clk_clk) begin
        edge_cnt = edge_cnt + 1;
        if (reset_reset_n && bus.vga_read && !bus.vga_waitrequest) begin
            vga_exp_q.push_back(ram[bus.vga_addr]);
            vga_cyc_q.push_back(edge_cnt + 1);
        end
        if (reset_reset_n && bus.cpu_read && !bus.cpu_write && !bus.cpu_waitrequest) begin
            cpu_exp_q.push_back(ram[bus.cpu_addr]);
            cpu_cyc_q.push_back(edge_cnt + 1);
        end
    end

    // Return monitor.
    always @(negedge clk_clk) begin
        logic [7:0] d;
        int         c;
        if (bus.vga_rvalid) begin
            if (vga_exp_q.size() == 0) check("vga_unexpected_rvalid", 1, 0);
            else begin
                d = vga_exp_q.pop_front();
                c = vga_cyc_q.pop_front();
                check("vga_rdata", bus.vga_rdata, d);
                check("vga_rvalid_cycle", edge_cnt, c);
            end
        end else if (vga_cyc_q.size() != 0 && vga_cyc_q[0] < edge_cnt) begin
            check("vga_missing_rvalid", 0, 1);
            void'(vga_exp_q.pop_front());
            void'(vga_cyc_q.pop_front());
        end
        if (bus.cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) check("cpu_unexpected_rvalid", 1, 0);
            else begin
                d = cpu_exp_q.pop_front();
                c = cpu_cyc_q.pop_front();
                check("cpu_rdata", bus.cpu_rdata, d);
                check("cpu_rvalid_cycle", edge_cnt, c);
            end
        end else if (cpu_cyc_q.size() != 0 && cpu_cyc_q[0] < edge_cnt) begin
            check("cpu_missing_rvalid", 0, 1);
            void'(cpu_exp_q.pop_front());
            void'(cpu_cyc_q.pop_front());
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       vr;
        logic [7:0] va;
        logic       cr;
        logic       cw;
        logic [7:0] ca;
        logic [7:0] cd;
        logic       e_vwait;
        logic       e_cwait;
        logic       e_we;
        logic [7:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vr, input logic [7:0] va, input logic cr, input logic cw,
                       input logic [7:0] ca, input logic [7:0] cd, input logic e_vwait,
                       input logic e_cwait, input logic e_we, input logic [7:0] e_addr);
        vec_t v;
        v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.e_vwait = e_vwait; v.e_cwait = e_cwait; v.e_we = e_we; v.e_addr = e_addr;
        vecs.push_back(v);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic vr, input logic [7:0] va, input logic cr, input logic cw,
                         input logic [7:0] ca, input logic [7:0] cd);
        bus.vga_read  = vr;
        bus.vga_addr  = va;
        bus.cpu_read  = cr;
        bus.cpu_write = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vga_wait"}, bus.vga_waitrequest, 1);
        check({tag, "_cpu_wait"}, bus.cpu_waitrequest, 1);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_vga_rvalid"}, bus.vga_rvalid, 0);
        check({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
        check({tag, "_vga_rdata"}, bus.vga_rdata, 0);
        check({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
        check({tag, "_tag"}, dbg_tag, 0);
        check({tag, "_starve"}, dbg_starve_cnt, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_reset_n = 1'b0;
        drive(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);

        //   vr va     cr cw ca     cd     vw cw we addr
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);  // idle
        add(1, 8'h05, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h05);  // VGA burst
        add(1, 8'h06, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h06);
        add(1, 8'h07, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h07);
        add(1, 8'h08, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h08);
        add(0, 8'h00, 0, 1, 8'h0A, 8'h7E, 0, 0, 1, 8'h0A);  // CPU write
        add(0, 8'h00, 1, 0, 8'h0A, 8'h00, 0, 0, 0, 8'h0A);  // CPU read back
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add(1, 8'h30, 0, 1, 8'h10, 8'h55, 0, 1, 0, 8'h30);  // contention x4
        add(1, 8'h30, 0, 1, 8'h10, 8'h55, 0, 1, 0, 8'h30);
        add(1, 8'h30, 0, 1, 8'h10, 8'h55, 0, 1, 0, 8'h30);
        add(1, 8'h30, 0, 1, 8'h10, 8'h55, 0, 1, 0, 8'h30);
        add(1, 8'h30, 0, 1, 8'h10, 8'h55, 1, 0, 1, 8'h10);  // forced CPU
        add(1, 8'h30, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h30);  // VGA resumes
        add(0, 8'h00, 1, 1, 8'h20, 8'h11, 0, 0, 1, 8'h20);  // rd+wr = write
        add(1, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01);  // interleaved
        add(0, 8'h00, 1, 0, 8'h02, 8'h00, 0, 0, 0, 8'h02);
        add(1, 8'h03, 1, 0, 8'h04, 8'h00, 0, 1, 0, 8'h03);  // CPU loses once
        add(0, 8'h00, 1, 0, 8'h04, 8'h00, 0, 0, 0, 8'h04);  // then wins
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);

        repeat (3) @(negedge clk_clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk_clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        reset_reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_clk);
            drive(vecs[i].vr, vecs[i].va, vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd);
            #1;
            check($sformatf("row%0d_vga_wait", i), bus.vga_waitrequest, vecs[i].e_vwait);
            check($sformatf("row%0d_cpu_wait", i), bus.cpu_waitrequest, vecs[i].e_cwait);
            check($sformatf("row%0d_mem_we", i), bus.mem_we, vecs[i].e_we);
            check($sformatf("row%0d_mem_addr", i), bus.mem_addr, vecs[i].e_addr);
        end
        repeat (3) @(negedge clk_clk);
        check("ram_0a", ram[8'h0A], 8'h7E);
        check("ram_10", ram[8'h10], 8'h55);
        check("ram_20", ram[8'h20], 8'h11);

        // Reset while a VGA read is in flight.
        @(negedge clk_clk);
        drive(1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 8'h00);
        #1 check("mid_rst_accept", bus.vga_waitrequest, 0);
        @(negedge clk_clk);
        #2;
        reset_reset_n = 1'b0;
        vga_exp_q.delete();
        vga_cyc_q.delete();
        cpu_exp_q.delete();
        cpu_cyc_q.delete();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check_reset_outputs("mid_rst");
        repeat (3) @(negedge clk_clk);
        #2 reset_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);
        check("post_rst_no_vga_rvalid", bus.vga_rvalid, 0);

        // Normal operation after release.
        drive(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
        #1 check("post_rst_vga_wait", bus.vga_waitrequest, 0);
        @(negedge clk_clk);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 8'h9C);
        #1 check("post_rst_cpu_wait", bus.cpu_waitrequest, 0);
        @(negedge clk_clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(negedge clk_clk);
        check("post_rst_vga_rdata", bus.vga_rdata, 8'h3C);
        check("ram_40", ram[8'h40], 8'h9C);

        check("vga_queue_drained", vga_exp_q.size(), 0);
        check("cpu_queue_drained", cpu_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
- Shares one single-port synchronous board/tile RAM between two Avalon-MM-style masters:
  - the VGA renderer, a read-only master with high priority;
  - the game-logic/Nios-bridge master, which reads and writes.
- Sits in FPGA fabric between the SoC export conduit and the on-chip board memory.
- Fixed priority, with a starvation guard so game-logic writes always complete while the renderer scans continuously.

Parameters:
- ADDR_W, 8, RAM address width (board is 10x20 = 200 cells).
- DATA_W, 8, RAM word width.
- STARVE_MAX, 4, number of consecutive denied CPU cycles after which the CPU is force-granted for one cycle; legal range 1..15.

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset_n  in  1  asynchronous active-low reset.
- vga_read  in  1  renderer read request.
- vga_addr  in  ADDR_W  renderer address.
- vga_waitrequest  out  1  renderer request not accepted this cycle.
- vga_rdata  out  DATA_W  renderer read data.
- vga_rvalid  out  1  vga_rdata valid pulse.
- cpu_read  in  1  CPU read request.
- cpu_write  in  1  CPU write request.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_waitrequest  out  1  CPU request not accepted this cycle.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid pulse.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address is sampled.

Behaviour:
- Request and acceptance:
  - A request is accepted at a rising edge when it is asserted and its waitrequest is low.
  - Masters hold address, data and control stable until accepted.
- Grant (combinational, each cycle):
  - force = cpu_req && starve_cnt == STARVE_MAX.
  - If force: CPU is granted.
  - Else if vga_read: VGA is granted.
  - Else if cpu_req: CPU is granted.
  - Else: nothing is granted.
  - cpu_req = cpu_read | cpu_write.
  - If cpu_read and cpu_write are both high, the request is treated as a write and no rvalid is produced.
- Waitrequest:
  - vga_waitrequest = vga_read & ~grant_vga.
  - cpu_waitrequest = cpu_req & ~grant_cpu.
  - Both are 1 while reset_reset_n is low.
- Memory drive (combinational from the grant):
  - mem_addr = address of the granted port; 0 when idle.
  - mem_we = grant_cpu & cpu_write.
  - mem_wdata = cpu_wdata.
- Pipeline tag:
  - A 2-bit tag register holds NONE, VGA_RD or CPU_RD, set at the acceptance edge.
  - Next edge: mem_rdata is captured into the owner's rdata register, and the owner's rvalid is set for exactly one cycle.
  - Read latency is 2 cycles: accepted at edge n, rvalid high during cycle n+2.
  - Back-to-back accepted reads produce back-to-back rvalid pulses.
  - rdata holds its value after rvalid drops.
- Starvation counter:
  - Increments at each edge where cpu_req && cpu_waitrequest, saturating at STARVE_MAX.
  - Clears to 0 on CPU acceptance or when cpu_req is low.
  - On a forced cycle the VGA request sees waitrequest high and is served the next cycle, because the counter is then 0.
- Write-then-read, same address, consecutive cycles: the read returns the new data (RAM write-first is not required; the write completes before the read address is sampled).
- Reset (asynchronous, any time):
  - Clears tag, starve_cnt, vga_rvalid, cpu_rvalid, vga_rdata and cpu_rdata to 0.
  - In-flight reads are dropped and no rvalid is emitted after reset release.
  - First grant is possible in the first cycle after reset_reset_n rises.

Test Plan:
- VGA only: vga_read=1, addr 0x05, RAM[5]=0x3C -> vga_waitrequest=0, vga_rvalid high 2 cycles later with vga_rdata=0x3C; a 4-address burst (0x05..0x08) gives 4 consecutive rvalid cycles.
- CPU write then read, VGA idle: write 0x0A<=0x7E, next cycle read 0x0A -> mem_we pulses 1 cycle, cpu_rvalid 2 cycles after the read with cpu_rdata=0x7E.
- Contention: vga_read held high continuously, cpu_write 0x10<=0x55 held -> cpu_waitrequest=1 for exactly STARVE_MAX=4 cycles, accepted in cycle 5 with vga_waitrequest=1 that cycle only, RAM[0x10]=0x55, VGA resumes next cycle.
- Simultaneous cpu_read=1 and cpu_write=1 at 0x20, wdata 0x11 -> treated as a write, RAM[0x20]=0x11, no cpu_rvalid.
- Interleaved reads: VGA reads 0x01, then CPU reads 0x02 the next cycle -> vga_rvalid then cpu_rvalid on consecutive cycles, each with correct data and no cross-routing.
- Reset mid-read: assert reset_reset_n=0 one cycle after a VGA read is accepted -> rvalid never asserts, all outputs 0 except both waitrequests=1, normal operation after release.
